hazard_ctrl_unit: RTL and testbench

- Parametrised hazard controller for the 5-stage RV32I pipeline; next generation of the single-cycle load-use/forwarding hazard logic.
- Adds a configurable load-use distance for slower data memories, a whole-pipeline freeze when the data memory is not ready, correct flush-over-stall priority, and x0 exclusion on load-use detection.
- Forwarding is combinational. A registered FSM with a down-counter owns all multi-cycle stalls.
- Sits between the decode/execute/memory/writeback pipeline registers and the PC register.

---
 rtl/hazard_ctrl_unit.sv | 162 ++++++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for the 5-stage RV32I pipeline: combinational forwarding plus
// a stall FSM (load-use bubbles, memory freeze). HAZARD_PERF_CNT_EN adds perf counters.

module hazard_fwd_lane #(
  parameter int ADDRESS_WIDTH = 5
) (
  input  logic [ADDRESS_WIDTH-1:0] rs,
  input  logic [ADDRESS_WIDTH-1:0] rd_m,
  input  logic [ADDRESS_WIDTH-1:0] rd_w,
  input  logic                     reg_write_m,
  input  logic                     reg_write_w,
  input  logic                     load_m,
  output logic [1:0]               sel
);
  // Load data is not available in M yet, so a load in M never feeds the bypass.
  always_comb begin
    sel = 2'd0;
    if (rs != '0) begin
      if (reg_write_m && !load_m && rs == rd_m) sel = 2'd2;
      else if (reg_write_w && rs == rd_w)       sel = 2'd1;
    end
  end
endmodule

module hazard_ctrl_unit #(
  parameter int ADDRESS_WIDTH   = 5,
  parameter int LOAD_USE_STALLS = 1,
  parameter int CNT_WIDTH       = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ADDRESS_WIDTH-1:0] Rs1D,
  input  logic [ADDRESS_WIDTH-1:0] Rs2D,
  input  logic [ADDRESS_WIDTH-1:0] Rs1E,
  input  logic [ADDRESS_WIDTH-1:0] Rs2E,
  input  logic [ADDRESS_WIDTH-1:0] RdE,
  input  logic [ADDRESS_WIDTH-1:0] RdM,
  input  logic [ADDRESS_WIDTH-1:0] RdW,
  input  logic                     RegWriteM,
  input  logic                     RegWriteW,
  input  logic                     ResultSrcE,
  input  logic                     ResultSrcM,
  input  logic                     PCSrcE,
  input  logic                     MemReadyM,
  output logic [1:0]               ForwardAE,
  output logic [1:0]               ForwardBE,
  output logic                     StallF,
  output logic                     StallD,
  output logic                     StallE,
  output logic                     StallM,
  output logic                     FlushD,
  output logic                     FlushE
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]              stall_cycles,
  output logic [31:0]              flush_events
`endif
);
  localparam int NUM_LANES = 2;

  typedef enum logic [1:0] {IDLE, LU_STALL, MEM_WAIT} state_t;

  logic [NUM_LANES-1:0][ADDRESS_WIDTH-1:0] rs_e;
  logic [NUM_LANES-1:0][1:0]               fwd;

  assign rs_e = {Rs2E, Rs1E};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    hazard_fwd_lane #(.ADDRESS_WIDTH(ADDRESS_WIDTH)) u_lane (
      .rs          (rs_e[i]),
      .rd_m        (RdM),
      .rd_w        (RdW),
      .reg_write_m (RegWriteM),
      .reg_write_w (RegWriteW),
      .load_m      (ResultSrcM),
      .sel         (fwd[i])
    );
  end

  assign ForwardAE = rst_n ? fwd[0] : 2'd0;
  assign ForwardBE = rst_n ? fwd[1] : 2'd0;

  state_t               state, state_nxt, saved, saved_nxt, cur;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic                 lu_hit;
  logic                 stall_fd, stall_em, flush_d, flush_e;

  assign lu_hit = ResultSrcE && (RdE != '0) && ((Rs1D == RdE) || (Rs2D == RdE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      saved <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      saved <= saved_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // A wait resumes in the same cycle ready returns, so the saved state's
  // behaviour (and any outstanding bubble) applies on that cycle.
  always_comb begin
    cur       = (state == MEM_WAIT) ? saved : state;
    state_nxt = state;
    saved_nxt = saved;
    cnt_nxt   = cnt;
    stall_fd  = 1'b0;
    stall_em  = 1'b0;
    flush_d   = 1'b0;
    flush_e   = 1'b0;
    if (!MemReadyM) begin
      stall_fd  = 1'b1;
      stall_em  = 1'b1;
      state_nxt = MEM_WAIT;
      saved_nxt = cur;
    end else begin
      state_nxt = cur;
      case (cur)
        LU_STALL: begin
          stall_fd = 1'b1;
          flush_e  = 1'b1;
          cnt_nxt  = cnt - CNT_WIDTH'(1);
          if (cnt == CNT_WIDTH'(1)) state_nxt = IDLE;
        end
        default: begin
          if (PCSrcE) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
          end else if (lu_hit) begin
            stall_fd = 1'b1;
            flush_e  = 1'b1;
            if (LOAD_USE_STALLS > 1) begin
              state_nxt = LU_STALL;
              cnt_nxt   = CNT_WIDTH'(LOAD_USE_STALLS - 1);
            end
          end
        end
      endcase
    end
  end

  assign StallF = rst_n & stall_fd;
  assign StallD = rst_n & stall_fd;
  assign StallE = rst_n & stall_em;
  assign StallM = rst_n & stall_em;
  assign FlushD = ~rst_n | flush_d;
  assign FlushE = ~rst_n | flush_e;

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (StallF && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
      if (FlushD && flush_events != '1) flush_events <= flush_events + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit (LOAD_USE_STALLS=3): bubble-budget model checked every
// negedge, plus directed vectors with literal expectations.
module tb_hazard_ctrl_unit;
  localparam int AW = 5, LUS = 3, CW = 3;

  logic clk = 1'b0, rst_n;
  logic [AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic RegWriteM, RegWriteW, ResultSrcE, ResultSrcM, PCSrcE, MemReadyM;
  logic [1:0] ForwardAE, ForwardBE;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_events;
  int pm_stall, pm_flush;
`endif
  int checks = 0, errors = 0;
  int m_left;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.ADDRESS_WIDTH(AW), .LOAD_USE_STALLS(LUS), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .ResultSrcE(ResultSrcE),
    .ResultSrcM(ResultSrcM), .PCSrcE(PCSrcE), .MemReadyM(MemReadyM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .flush_events(flush_events)
`endif
  );

  function automatic logic m_lu();
    return ResultSrcE && RdE != 0 && (Rs1D == RdE || Rs2D == RdE);
  endfunction

  function automatic logic [1:0] m_fwd(input logic [AW-1:0] rs);
    if (!rst_n || rs == 0) return 2'd0;
    if (RegWriteM && !ResultSrcM && rs == RdM) return 2'd2;
    if (RegWriteW && rs == RdW) return 2'd1;
    return 2'd0;
  endfunction

  // {StallF, StallD, StallE, StallM, FlushD, FlushE}
  function automatic logic [5:0] m_ctrl();
    if (!rst_n) return 6'b000011;
    if (!MemReadyM) return 6'b111100;
    if (m_left > 0) return 6'b110001;
    if (PCSrcE) return 6'b000011;
    if (m_lu()) return 6'b110001;
    return 6'b000000;
  endfunction

  // Model: count of bubbles still owed; a freeze consumes none of them.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0;
`ifdef HAZARD_PERF_CNT_EN
      pm_stall <= 0;
      pm_flush <= 0;
`endif
    end else begin
`ifdef HAZARD_PERF_CNT_EN
      if (m_ctrl() & 6'b100000) pm_stall <= pm_stall + 1;
      if (m_ctrl() & 6'b000010) pm_flush <= pm_flush + 1;
`endif
      if (MemReadyM) begin
        if (m_left > 0) m_left <= m_left - 1;
        else if (!PCSrcE && m_lu()) m_left <= LUS - 1;
      end
    end
  end

  always @(negedge clk) begin
    logic [5:0] act, exp;
    act = {StallF, StallD, StallE, StallM, FlushD, FlushE};
    exp = m_ctrl();
    if (rst_n && MemReadyM && m_left > 0)
      assert (!PCSrcE) else $error("PCSrcE raised while a load-use bubble is in E");
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL ctrl t=%0t act=%b exp=%b", $time, act, exp);
    end
    checks++;
    if ({ForwardAE, ForwardBE} !== {m_fwd(Rs1E), m_fwd(Rs2E)}) begin
      errors++;
      $display("FAIL fwd t=%0t act=%0d/%0d exp=%0d/%0d", $time, ForwardAE, ForwardBE,
               m_fwd(Rs1E), m_fwd(Rs2E));
    end
  end

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    RegWriteM = 0; RegWriteW = 0; ResultSrcE = 0; ResultSrcM = 0; PCSrcE = 0;
  endtask

  initial begin
    rst_n = 1'b0; MemReadyM = 1'b1;
    clr();
    #3;
    lit("rst_flush", {FlushD, FlushE}, 2'b11);
    lit("rst_stall", {StallF, StallD, StallE, StallM}, 4'b0000);
    lit("rst_fwd", ForwardAE, 2'd0);
`ifdef HAZARD_PERF_CNT_EN
    lit("rst_perf", stall_cycles | flush_events, 32'd0);
`endif
    #4 rst_n = 1'b1;

    // forwarding
    tick();
    RdM = 5; RegWriteM = 1; ResultSrcM = 0; Rs1E = 5; RdW = 5; RegWriteW = 1;
    #1 lit("fwd_m", ForwardAE, 2'd2);
    ResultSrcM = 1;
    #1 lit("fwd_load_in_m", ForwardAE, 2'd1);
    Rs1E = 0;
    #1 lit("fwd_x0", ForwardAE, 2'd0);
    tick();
    Rs2E = 5;
    #1 lit("fwd_b_w", ForwardBE, 2'd1);
    tick(); clr();

    // load-use, three bubbles
    tick();
    ResultSrcE = 1; RdE = 7; Rs2D = 7;
    #1 lit("lu_b1", {StallF, StallD, FlushE}, 3'b111);
    tick(); clr();
    #1 lit("lu_b2", {StallF, StallD, FlushE}, 3'b111);
    tick();
    #1 lit("lu_b3", {StallF, StallD, FlushE}, 3'b111);
    tick();
    #1 lit("lu_done", {StallF, StallD, StallE, StallM, FlushD, FlushE}, 6'b0);
    ResultSrcE = 1; RdE = 0;
    #1 lit("lu_x0", {StallF, FlushE}, 2'b00);
    tick(); clr();

    // flush beats load-use
    tick();
    ResultSrcE = 1; RdE = 7; Rs1D = 7; PCSrcE = 1;
    #1 lit("flush_prio", {FlushD, FlushE, StallF}, 3'b110);
    tick(); clr();
    #1 lit("flush_no_stall", {StallF, FlushE}, 2'b00);

    // memory freeze in the middle of a load-use
    tick();
    ResultSrcE = 1; RdE = 7; Rs1D = 7;
    #1 lit("frz_b1", {StallF, FlushE}, 2'b11);
    tick(); clr();
    #1 lit("frz_b2", {StallF, StallM, FlushE}, 3'b101);
    for (int i = 0; i < 4; i++) begin
      tick(); MemReadyM = 0;
      #1 lit("frz_hold", {StallF, StallD, StallE, StallM, FlushD, FlushE}, 6'b111100);
    end
    tick(); MemReadyM = 1;
    #1 lit("frz_last_bubble", {StallF, StallD, StallM, FlushE}, 4'b1101);
    tick();
    #1 lit("frz_done", {StallF, StallD, StallE, StallM, FlushD, FlushE}, 6'b0);

    // branch during a freeze waits for ready
    tick(); MemReadyM = 0; PCSrcE = 1;
    #1 lit("frz_branch_ignored", {FlushD, StallE}, 2'b01);
    tick(); MemReadyM = 1;
    #1 lit("frz_branch_after", {FlushD, FlushE, StallF}, 3'b110);
    tick(); clr();

    // reset while stalling
    tick();
    ResultSrcE = 1; RdE = 7; Rs2D = 7;
    tick(); clr();
    #1 lit("rstmid_bubble", StallF, 1'b1);
`ifdef HAZARD_PERF_CNT_EN
    lit("perf_stall", stall_cycles, pm_stall);
    lit("perf_flush", flush_events, pm_flush);
`endif
    rst_n = 1'b0;
    #1 lit("rstmid_flush", {FlushD, FlushE, StallF, StallD}, 4'b1100);
`ifdef HAZARD_PERF_CNT_EN
    lit("rstmid_perf", stall_cycles | flush_events, 32'd0);
`endif
    @(negedge clk); #1 rst_n = 1'b1;
    tick();
    #1 lit("post_rst", {StallF, StallD, StallE, StallM, FlushD, FlushE}, 6'b0);
    tick();
    #1 lit("post_rst2", {StallF, FlushE}, 2'b00);
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
